// File: rtl/ps2_pkg.sv
// ps2_pkg: scan-code set 2 constants, ignored responses and decode states
package ps2_pkg;
  localparam logic [7:0] PFX_EXT    = 8'hE0;
  localparam logic [7:0] PFX_BRK    = 8'hF0;
  localparam logic [7:0] PFX_PAUSE  = 8'hE1;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;
  localparam logic [8:0] KEY_SPACE  = 9'h029;
  typedef enum logic [2:0] {D_PLAIN, D_EXT, D_BRK, D_EXT_BRK, D_SKIP} dstate_t;
  // keyboard responses and status bytes that never describe a key
  function automatic logic is_ignored(input logic [7:0] b);
    return b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hFC, 8'h00, 8'hFF};
  endfunction
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronise, filter and deserialise device-to-host PS/2 frames
module ps2_frame_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [1:0] clk_sync_q, dat_sync_q;
  logic filt_q, filt_d, par_q, par_d, bv_q, bv_d, err_q, err_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [TW-1:0] to_q, to_d;
  logic clk_s, dat_s, flip, fall, ok;
  // filtered clock flips only after FILTER_LEN consecutive samples of the new level
  always_comb begin
    clk_s  = clk_sync_q[1];
    dat_s  = dat_sync_q[1];
    flip   = (clk_s != filt_q) && (fcnt_q == FW'(FILTER_LEN - 1));
    fcnt_d = (clk_s != filt_q && !flip) ? fcnt_q + 1'b1 : '0;
    filt_d = flip ? clk_s : filt_q;
    fall   = flip & ~clk_s;
  end
  // bit assembly, parity/stop check and mid-frame timeout; a fall beats a timeout
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    bv_d      = 1'b0;
    err_d     = 1'b0;
    ok        = (^{shift_q, par_q}) & dat_s;
    to_d      = (bit_cnt_q != 4'd0) ? to_q + 1'b1 : '0;
    if (fall) begin
      to_d = '0;
      if (bit_cnt_q == 4'd0) begin
        err_d     = dat_s;
        bit_cnt_d = dat_s ? 4'd0 : 4'd1;
      end else if (bit_cnt_q <= 4'd8) begin
        shift_d   = {dat_s, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else if (bit_cnt_q == 4'd9) begin
        par_d     = dat_s;
        bit_cnt_d = 4'd10;
      end else begin
        bit_cnt_d = 4'd0;
        bv_d      = ok;
        err_d     = ~ok;
      end
    end else if (bit_cnt_q != 4'd0 && to_q == TW'(TIMEOUT_CYC - 1)) begin
      err_d     = 1'b1;
      bit_cnt_d = 4'd0;
      to_d      = '0;
    end
  end
  // all receive state; synchronisers and filter idle high like the bus
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      par_q      <= 1'b0;
      to_q       <= '0;
      bv_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      to_q       <= to_d;
      bv_q       <= bv_d;
      err_q      <= err_d;
    end
  end
  assign rx_byte    = shift_q;
  assign byte_valid = bv_q;
  assign frame_err  = err_q;
endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: decodes set 2 make/break/extended codes into a pressed-key map
module ps2_key_tracker import ps2_pkg::*; #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic         pclk,
  input  logic         rst,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic [511:0] key_down,
  output logic [8:0]   last_change,
  output logic         key_valid,
  output logic         frame_err
);
  logic [7:0] rx_byte;
  logic byte_valid, rx_err, ext, brk, ev, kv_q, kv_d;
  dstate_t state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic [511:0] key_down_q, key_down_d;
  logic [8:0] last_q, last_d;
  ps2_frame_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .pclk(pclk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_byte(rx_byte), .byte_valid(byte_valid), .frame_err(rx_err)
  );
  // decode state and pause skip counter
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q <= D_PLAIN;
      skip_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end
  // prefix tracking; a bad frame drops any pending prefix or pause
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    if (rx_err) begin
      state_d = D_PLAIN;
      skip_d  = 3'd0;
    end else if (byte_valid) begin
      case (state_q)
        D_PLAIN: begin
          state_d = rx_byte == PFX_EXT ? D_EXT : rx_byte == PFX_BRK ? D_BRK :
                    rx_byte == PFX_PAUSE ? D_SKIP : D_PLAIN;
          skip_d  = rx_byte == PFX_PAUSE ? PAUSE_SKIP : 3'd0;
        end
        D_EXT:  state_d = rx_byte == PFX_BRK ? D_EXT_BRK : D_PLAIN;
        D_BRK:  state_d = rx_byte == PFX_EXT ? D_EXT_BRK : D_PLAIN;
        D_SKIP: begin
          skip_d  = skip_q - 3'd1;
          state_d = skip_q == 3'd1 ? D_PLAIN : D_SKIP;
        end
        default: state_d = D_PLAIN;
      endcase
    end
  end
  // key event detection and the resulting map / last-change update
  always_comb begin
    ext = state_q == D_EXT || state_q == D_EXT_BRK;
    brk = state_q == D_BRK || state_q == D_EXT_BRK;
    ev  = byte_valid && (state_q == D_EXT_BRK ||
          (state_q == D_EXT && rx_byte != PFX_BRK) ||
          (state_q == D_BRK && rx_byte != PFX_EXT) ||
          (state_q == D_PLAIN && !(rx_byte inside {PFX_EXT, PFX_BRK, PFX_PAUSE}) && !is_ignored(rx_byte)));
    kv_d       = ev;
    last_d     = ev ? {ext, rx_byte} : last_q;
    key_down_d = key_down_q;
    if (ev) key_down_d[{ext, rx_byte}] = ~brk;
  end
  // registered outputs so key_valid coincides with the map update
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      key_down_q <= '0;
      last_q     <= 9'd0;
      kv_q       <= 1'b0;
    end else begin
      key_down_q <= key_down_d;
      last_q     <= last_d;
      kv_q       <= kv_d;
    end
  end
  assign key_down    = key_down_q;
  assign last_change = last_q;
  assign key_valid   = kv_q;
  assign frame_err   = rx_err;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: table, directed and random checks of the PS/2 key tracker
module tb_ps2_key_tracker;
  logic pclk = 1'b0, rst = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [511:0] key_down;
  logic [8:0] last_change;
  logic key_valid, frame_err;
  int checks = 0, errors = 0, kv_cnt = 0, err_cnt = 0, overlap = 0;
  int kv0, e0, ev0;
  bit [511:0] m_keys;
  logic [8:0] m_last;
  int m_ev = 0, m_skip = 0;
  bit m_ext, m_brk;
  typedef struct {
    logic [7:0] b;
    bit bad;
    int kv;
    int er;
    logic [8:0] last;
    logic [8:0] probe;
    bit pv;
  } vec_t;
  vec_t tbl[$];
  logic [7:0] pool [12] = '{8'h29, 8'h1C, 8'h74, 8'h14, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hFF};

  ps2_key_tracker dut (
    .pclk(pclk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_down(key_down), .last_change(last_change), .key_valid(key_valid), .frame_err(frame_err)
  );

  always #20 pclk = ~pclk;

  always @(negedge pclk) begin
    if (key_valid) kv_cnt++;
    if (frame_err) err_cnt++;
    if (key_valid && frame_err) overlap++;
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic send_bit(input logic v);
    ps2_data = v;
    cyc(6);
    ps2_clk = 1'b0;
    cyc(12);
    ps2_clk = 1'b1;
    cyc(6);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(bad ? ^b : ~^b);
    send_bit(1'b1);
    ps2_data = 1'b1;
    cyc(6);
  endtask

  // behavioural model: prefix flags plus a pause byte budget
  function automatic void model_byte(input logic [7:0] b);
    if (m_skip > 0) m_skip--;
    else if (!m_ext && !m_brk && b == 8'hE1) m_skip = 7;
    else if (b == 8'hE0 && !m_ext) m_ext = 1'b1;
    else if (b == 8'hF0 && !m_brk) m_brk = 1'b1;
    else if (!m_ext && !m_brk && b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hFC, 8'h00, 8'hFF}) begin end
    else begin
      m_last = {m_ext, b};
      m_keys[m_last] = ~m_brk;
      m_ev++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  function automatic void model_err();
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_skip = 0;
  endfunction

  task automatic frame_m(input logic [7:0] b, input bit bad);
    send_frame(b, bad);
    if (bad) model_err();
    else model_byte(b);
  endtask

  initial begin
    m_keys = '0;
    m_last = 9'd0;
    tbl.push_back(vec_t'{8'h29, 0, 1, 0, 9'h029, 9'h029, 1});
    tbl.push_back(vec_t'{8'hF0, 0, 0, 0, 9'h029, 9'h029, 1});
    tbl.push_back(vec_t'{8'h29, 0, 1, 0, 9'h029, 9'h029, 0});
    tbl.push_back(vec_t'{8'hE0, 0, 0, 0, 9'h029, 9'h174, 0});
    tbl.push_back(vec_t'{8'h74, 0, 1, 0, 9'h174, 9'h174, 1});
    tbl.push_back(vec_t'{8'hE0, 0, 0, 0, 9'h174, 9'h074, 0});
    tbl.push_back(vec_t'{8'hF0, 0, 0, 0, 9'h174, 9'h174, 1});
    tbl.push_back(vec_t'{8'h74, 0, 1, 0, 9'h174, 9'h174, 0});
    tbl.push_back(vec_t'{8'h29, 1, 0, 1, 9'h174, 9'h029, 0});
    tbl.push_back(vec_t'{8'h1C, 0, 1, 0, 9'h01C, 9'h01C, 1});
    tbl.push_back(vec_t'{8'hF0, 0, 0, 0, 9'h01C, 9'h01C, 1});
    tbl.push_back(vec_t'{8'h55, 1, 0, 1, 9'h01C, 9'h01C, 1});
    tbl.push_back(vec_t'{8'h29, 0, 1, 0, 9'h029, 9'h029, 1});
    tbl.push_back(vec_t'{8'h29, 0, 1, 0, 9'h029, 9'h029, 1});
    tbl.push_back(vec_t'{8'hF0, 0, 0, 0, 9'h029, 9'h033, 0});
    tbl.push_back(vec_t'{8'h33, 0, 1, 0, 9'h033, 9'h033, 0});
    tbl.push_back(vec_t'{8'hAA, 0, 0, 0, 9'h033, 9'h0AA, 0});
    tbl.push_back(vec_t'{8'hFA, 0, 0, 0, 9'h033, 9'h0FA, 0});
    tbl.push_back(vec_t'{8'hE1, 0, 0, 0, 9'h033, 9'h0E1, 0});
    tbl.push_back(vec_t'{8'h14, 0, 0, 0, 9'h033, 9'h014, 0});
    tbl.push_back(vec_t'{8'h77, 0, 0, 0, 9'h033, 9'h077, 0});
    tbl.push_back(vec_t'{8'hE1, 0, 0, 0, 9'h033, 9'h0E1, 0});
    tbl.push_back(vec_t'{8'hF0, 0, 0, 0, 9'h033, 9'h014, 0});
    tbl.push_back(vec_t'{8'h14, 0, 0, 0, 9'h033, 9'h014, 0});
    tbl.push_back(vec_t'{8'hF0, 0, 0, 0, 9'h033, 9'h077, 0});
    tbl.push_back(vec_t'{8'h77, 0, 0, 0, 9'h033, 9'h077, 0});
    tbl.push_back(vec_t'{8'h29, 0, 1, 0, 9'h029, 9'h029, 1});

    cyc(3);
    chk("rst_key_down", key_down, '0);
    chk("rst_last", last_change, 9'd0);
    chk("rst_kv", key_valid, 1'b0);
    chk("rst_err", frame_err, 1'b0);
    rst = 1'b1;
    cyc(50);
    chk("idle_pulses", kv_cnt + err_cnt, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      kv0 = kv_cnt;
      e0 = err_cnt;
      frame_m(tbl[i].b, tbl[i].bad);
      chk($sformatf("vec%0d_kv", i), kv_cnt - kv0, tbl[i].kv);
      chk($sformatf("vec%0d_err", i), err_cnt - e0, tbl[i].er);
      chk($sformatf("vec%0d_last", i), last_change, tbl[i].last);
      chk($sformatf("vec%0d_key", i), key_down[tbl[i].probe], tbl[i].pv);
    end
    chk("ext_074_never", key_down[9'h074], 1'b0);

    kv0 = kv_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 5; i++) send_bit(i == 0 ? 1'b0 : 1'b1);
    cyc(50010);
    chk("timeout_err", err_cnt - e0, 1);
    chk("timeout_kv", kv_cnt - kv0, 0);
    model_err();
    frame_m(8'h1C, 1'b0);
    chk("after_to_kv", kv_cnt - kv0, 1);
    chk("after_to_err", err_cnt - e0, 1);
    chk("after_to_last", last_change, 9'h01C);
    chk("after_to_key", key_down[9'h01C], 1'b1);

    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    rst = 1'b0;
    cyc(2);
    chk("midrst_key_down", key_down, '0);
    chk("midrst_last", last_change, 9'd0);
    chk("midrst_kv", key_valid, 1'b0);
    chk("midrst_err", frame_err, 1'b0);
    ps2_data = 1'b1;
    m_keys = '0;
    m_last = 9'd0;
    model_err();
    cyc(3);
    rst = 1'b1;
    kv0 = kv_cnt;
    e0 = err_cnt;
    cyc(300);
    chk("post_rst_pulses", (kv_cnt - kv0) + (err_cnt - e0), 0);

    for (int n = 0; n < 60; n++) begin
      int r;
      logic [7:0] b;
      bit bad;
      r = $urandom_range(0, 15);
      b = (r < 12) ? pool[r] : 8'($urandom);
      bad = ($urandom_range(0, 9) == 0);
      kv0 = kv_cnt;
      ev0 = m_ev;
      frame_m(b, bad);
      chk($sformatf("rnd%0d_kv", n), kv_cnt - kv0, m_ev - ev0);
      chk($sformatf("rnd%0d_last", n), last_change, m_last);
      chk($sformatf("rnd%0d_keys", n), key_down, m_keys);
    end

    chk("kv_err_overlap", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Upstream neighbour of the game logic block: turns the raw PS/2 keyboard line into the key_down / last_change / key_valid interface that the game logic consumes for jump detection (space = 9'h029).
- Deserialises device-to-host PS/2 frames, decodes scan-code set 2 make, break and extended prefixes, and keeps a 512-entry pressed-key map.
- Runs entirely in the pclk (25 MHz pixel clock) domain. PS/2 lines are asynchronous inputs.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised ps2_clk samples required before the filtered clock changes.
- TIMEOUT_CYC, 50000: pclk cycles without a filtered falling edge mid-frame before the frame is aborted (2 ms at 25 MHz).

Ports:
- pclk  in  1  system clock, one clock domain.
- rst  in  1  reset, asynchronous, active-low.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- key_down  out  512  bit [{ext,code}] is 1 while that key is held.
- last_change  out  9  {ext, code[7:0]} of the most recent make or break.
- key_valid  out  1  one-cycle pulse; last_change and key_down are updated in that same cycle.
- frame_err  out  1  one-cycle pulse on a discarded frame.

Behaviour:
- Reset (rst=0, asynchronous):
  - key_down, last_change, key_valid and frame_err all go to 0.
  - Synchronisers go to 1. The filtered clock goes to 1.
  - The bit counter goes to 0. The decode FSM goes to D_PLAIN. The skip counter goes to 0.
  - Reset mid-frame discards any partial frame. No pulse is issued after release.
- Input conditioning:
  - Both inputs use 2-FF synchronisers.
  - The filtered clock toggles only after FILTER_LEN equal samples.
  - fall = filtered clock 1->0. ps2_data (synchronised) is sampled on fall.
- Frame receive (sub-module):
  - A frame is 11 bits: start(0), d0..d7 LSB first, odd parity, stop(1). bit_cnt runs 0..10.
  - bit_cnt=0 with sampled start=1: frame_err, bit_cnt stays 0.
  - On bit 10: if parity is odd and stop=1, byte_valid pulses for one cycle, 1 cycle after fall. Otherwise frame_err pulses and no byte is produced.
  - A timeout counter clears on every fall. While bit_cnt!=0, reaching TIMEOUT_CYC gives frame_err and bit_cnt=0.
  - If fall and timeout land in the same cycle, fall wins.
- Decode FSM, states D_PLAIN, D_EXT, D_BRK, D_EXT_BRK, D_SKIP. Acts on byte_valid:
  - 0xE0: from PLAIN -> EXT; from BRK -> EXT_BRK.
  - 0xF0: from PLAIN -> BRK; from EXT -> EXT_BRK.
  - 0xE1 in PLAIN: -> D_SKIP with skip=7. Each byte decrements skip; at 0 -> PLAIN. Pause generates no events.
  - 0xAA, 0xFA, 0xFE, 0xEE, 0xFC, 0x00, 0xFF in PLAIN: ignored, stay PLAIN.
  - Any other byte b: code = {ext,b}. key_down[code] <= ~brk, last_change <= code, key_valid=1 in the cycle after byte_valid, then -> PLAIN.
  - Total latency from fall on the stop bit to key_valid is 2 pclk cycles.
  - Typematic repeat (repeated make of a held key): key_valid pulses again with the same last_change. key_down stays 1.
  - A break of a key not held: key_down stays 0, key_valid still pulses.
  - frame_err in any decode state: FSM -> PLAIN, skip=0. A pending prefix is dropped, key_down is unchanged.
  - key_valid and frame_err are never asserted in the same cycle.

Decomposition:
- Package ps2_pkg holds:
  - constants PFX_EXT=8'hE0, PFX_BRK=8'hF0, PFX_PAUSE=8'hE1, PAUSE_SKIP=7;
  - the ignored-response code list;
  - KEY_SPACE=9'h029;
  - the decode-state enum.
- Sub-module ps2_frame_rx: synchroniser, filter, deserialiser, parity/stop check and timeout. Outputs byte[7:0], byte_valid, frame_err.
- ps2_key_tracker keeps the decode FSM and the key map.

Test Plan:
- Frames 29, then F0 29 -> key_valid, last_change=9'h029, key_down[9'h029]=1; after the break: a second key_valid, last_change=9'h029, key_down[9'h029]=0.
- Frames E0 74, then E0 F0 74 -> last_change=9'h174, key_down[9'h174]=1 then 0; key_down[9'h074] stays 0 throughout.
- Frame 0x29 with even parity -> frame_err pulse, no key_valid, key_down unchanged. A following valid 0x1C gives last_change=9'h01C.
- Clock stalls after 5 bits for 50001 cycles -> exactly one frame_err. A following full frame 0x29 decodes correctly.
- F0 frame, then a corrupted frame, then 0x29 -> the prefix is dropped: key_down[9'h029]=1 (make, not break).
- Pause sequence E1 14 77 E1 F0 14 F0 77 -> zero key_valid pulses, FSM ends in D_PLAIN. rst=0 asserted mid-frame -> all outputs 0, no pulse after release.
